// File: rtl/exception_ctrl_pkg.sv
// Shared definitions for the exception controller: CP0 register indices, exception codes,
// Status/Cause bit positions, FSM state encoding and register packing helpers.
package exception_ctrl_pkg;

  // CP0 register indices (MFC0/MTC0 rd field)
  localparam logic [4:0] Cp0IdxStatus = 5'd12;
  localparam logic [4:0] Cp0IdxCause  = 5'd13;
  localparam logic [4:0] Cp0IdxEpc    = 5'd14;

  // Cause.ExcCode values
  localparam logic [4:0] ExcCodeInt = 5'd0;
  localparam logic [4:0] ExcCodeSys = 5'd8;

  // Bit positions inside Status and Cause
  localparam int unsigned StatusIeBit  = 0;
  localparam int unsigned StatusExlBit = 1;
  localparam int unsigned StatusImLsb  = 8;
  localparam int unsigned CauseExcLsb  = 2;
  localparam int unsigned CauseIpLsb   = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StFlush    = 2'd1,
    StRedirect = 2'd2
  } exc_state_e;

  function automatic logic [31:0] pack_status(logic [7:0] im, logic exl, logic ie);
    logic [31:0] r;
    r = '0;
    r[StatusImLsb +: 8] = im;
    r[StatusExlBit]     = exl;
    r[StatusIeBit]      = ie;
    return r;
  endfunction

  function automatic logic [31:0] pack_cause(logic [7:0] ip, logic [4:0] exc_code);
    logic [31:0] r;
    r = '0;
    r[CauseIpLsb +: 8]  = ip;
    r[CauseExcLsb +: 5] = exc_code;
    return r;
  endfunction

endpackage

// File: rtl/exception_ctrl_cp0_regfile.sv
// CP0 register storage: Status (IM/EXL/IE), Cause (IP/ExcCode) and EPC.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   irq_i             interrupt lines, zero-padded to 8, sampled into Cause.IP every cycle
//   exc_take_i        exception entry: load EPC/ExcCode, set EXL
//   exc_code_i        ExcCode to record on entry
//   exc_epc_i         EPC to record on entry
//   eret_take_i       ERET: clear EXL
//   mtc0_we_i         MTC0 write strobe (already priority-qualified)
//   sel_i, wdata_i    register index and write data (index also drives the read mux)
//   rdata_o           combinational read data for sel_i
//   ie_o, exl_o, im_o, ip_o, epc_o   current register fields
module exception_ctrl_cp0_regfile
  import exception_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  irq_i,
  input  logic        exc_take_i,
  input  logic [4:0]  exc_code_i,
  input  logic [31:0] exc_epc_i,
  input  logic        eret_take_i,
  input  logic        mtc0_we_i,
  input  logic [4:0]  sel_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ie_o,
  output logic        exl_o,
  output logic [7:0]  im_o,
  output logic [7:0]  ip_o,
  output logic [31:0] epc_o
);

  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic [7:0]  im_q, im_d;
  logic [7:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  // Entry/ERET/MTC0 are mutually exclusive by construction in the parent.
  always_comb begin
    ie_d       = ie_q;
    exl_d      = exl_q;
    im_d       = im_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    ip_d       = irq_i;
    if (exc_take_i) begin
      epc_d      = exc_epc_i;
      exc_code_d = exc_code_i;
      exl_d      = 1'b1;
    end else if (eret_take_i) begin
      exl_d = 1'b0;
    end else if (mtc0_we_i) begin
      // Cause is read-only to software here; unknown indices drop the write.
      unique case (sel_i)
        Cp0IdxStatus: begin
          im_d  = wdata_i[StatusImLsb +: 8];
          exl_d = wdata_i[StatusExlBit];
          ie_d  = wdata_i[StatusIeBit];
        end
        Cp0IdxEpc: epc_d = wdata_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ie_q       <= 1'b0;
      exl_q      <= 1'b0;
      im_q       <= '0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      ie_q       <= ie_d;
      exl_q      <= exl_d;
      im_q       <= im_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // No write bypass: a same-cycle MTC0 read returns the old value.
  always_comb begin
    rdata_o = '0;
    unique case (sel_i)
      Cp0IdxStatus: rdata_o = pack_status(im_q, exl_q, ie_q);
      Cp0IdxCause:  rdata_o = pack_cause(ip_q, exc_code_q);
      Cp0IdxEpc:    rdata_o = epc_q;
      default:      rdata_o = '0;
    endcase
  end

  assign ie_o  = ie_q;
  assign exl_o = exl_q;
  assign im_o  = im_q;
  assign ip_o  = ip_q;
  assign epc_o = epc_q;

endmodule

// File: rtl/exception_ctrl.sv
// Exception/interrupt/ERET sequencer holding the CP0 registers.
// Evaluates EX-stage events in IDLE (interrupt > syscall > eret > mtc0) and runs a
// two-cycle FLUSH -> REDIRECT sequence towards the fetch logic.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   instr_valid, pc              EX-stage instruction valid and its PC
//   s_syscall/s_eret/s_mtc0/s_mfc0  decoded strobes
//   cp0_sel, cp0_wdata           CP0 index and MTC0 data
//   irq                          level-sensitive interrupt lines
//   cp0_rdata                    combinational MFC0 data
//   flush, stall                 pipeline kill / PC and IF/ID freeze
//   redirect_valid, redirect_pc  PC load request and target
//   exl                          Status.EXL
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter int unsigned N_IRQ      = 8,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      pc,
  input  logic             s_syscall,
  input  logic             s_eret,
  input  logic             s_mtc0,
  input  logic             s_mfc0,
  input  logic [4:0]       cp0_sel,
  input  logic [31:0]      cp0_wdata,
  input  logic [N_IRQ-1:0] irq,
  output logic [31:0]      cp0_rdata,
  output logic             flush,
  output logic             stall,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             exl
);

  exc_state_e  state_q, state_d;
  logic [31:0] target_q, target_d;

  logic [7:0]  irq_ext;
  logic        ie, exl_int;
  logic [7:0]  im, ip;
  logic [31:0] epc;

  logic irq_pend, ev_valid;
  logic take_int, take_sys, take_eret, take_mtc0, exc_take;

  // MFC0 needs no sequencing; the read mux is driven by cp0_sel alone.
  logic unused_mfc0;
  assign unused_mfc0 = s_mfc0;

  always_comb begin
    irq_ext = '0;
    irq_ext[N_IRQ-1:0] = irq;
  end

  assign irq_pend = ie & ~exl_int & (|(ip & im));
  assign ev_valid = (state_q == StIdle) & instr_valid;

  // Strict priority; anything below the winner is dropped.
  assign take_int  = ev_valid & irq_pend;
  assign take_sys  = ev_valid & ~irq_pend & s_syscall;
  assign take_eret = ev_valid & ~irq_pend & ~s_syscall & s_eret;
  assign take_mtc0 = ev_valid & ~irq_pend & ~s_syscall & ~s_eret & s_mtc0;
  assign exc_take  = take_int | take_sys;

  exception_ctrl_cp0_regfile u_cp0 (
    .clk_i       (clk),
    .rst_i       (rst),
    .irq_i       (irq_ext),
    .exc_take_i  (exc_take),
    .exc_code_i  (take_int ? ExcCodeInt : ExcCodeSys),
    .exc_epc_i   (pc),
    .eret_take_i (take_eret),
    .mtc0_we_i   (take_mtc0),
    .sel_i       (cp0_sel),
    .wdata_i     (cp0_wdata),
    .rdata_o     (cp0_rdata),
    .ie_o        (ie),
    .exl_o       (exl_int),
    .im_o        (im),
    .ip_o        (ip),
    .epc_o       (epc)
  );

  // Target is captured at the event edge so ERET sees EPC as it was before that edge.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    unique case (state_q)
      StIdle: begin
        if (exc_take || take_eret) begin
          state_d  = StFlush;
          target_d = take_eret ? epc : EXC_VECTOR;
        end
      end
      StFlush:    state_d = StRedirect;
      StRedirect: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    flush          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (state_q)
      StFlush: begin
        flush = 1'b1;
        stall = 1'b1;
      end
      StRedirect: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
      end
      default: ;
    endcase
  end

  assign exl = exl_int;

endmodule
